// File: rtl/ika9958_sync_strobe_gen.sv
// VDP H/V dot and line counter with registered set/reset strobes for the
// HSYNC, HBLANK and VSYNC latches; horizontal adjust and PAL select are boundary-latched.
module ika9958_sync_strobe_gen #(
    parameter int H_TOTAL  = 342,
    parameter int HS_START = 0,
    parameter int HS_END   = 25,
    parameter int HB_START = 284,
    parameter int HB_END   = 58,
    parameter int V_NTSC   = 262,
    parameter int V_PAL    = 313,
    parameter int VS_LINES = 3
) (
    input  logic       i_CLK,
    input  logic       i_RST_n,
    input  logic       i_CEN,
    input  logic [3:0] i_HADJ,
    input  logic       i_PAL,
    output logic [8:0] o_HCNT,
    output logic [8:0] o_VCNT,
    output logic       o_HSYNC_S,
    output logic       o_HSYNC_R,
    output logic       o_HBLANK_S,
    output logic       o_HBLANK_R,
    output logic       o_VSYNC_S,
    output logic       o_VSYNC_R,
    output logic       o_LINE_END,
    output logic       o_FRAME_END
);

    localparam logic [8:0]        H_LAST  = 9'(H_TOTAL - 1);
    localparam logic [8:0]        VN_LAST = 9'(V_NTSC - 1);
    localparam logic [8:0]        VP_LAST = 9'(V_PAL - 1);
    localparam logic signed [9:0] H_TOT   = 10'(H_TOTAL);

    logic [8:0] hcnt, vcnt, h_nxt, v_nxt, v_last;
    logic [8:0] hs_s_pos, hs_e_pos;
    logic [3:0] adj_q, adj_nxt;
    logic       pal_q, pal_nxt;
    logic       line_end, frame_end;
    logic [5:0] stb_q, stb_nxt;
    logic       hs_s, hs_r, hb_s, hb_r, vs_s, vs_r;

    // Nominal position minus signed adjust, folded back into one line.
    function automatic logic [8:0] hs_pos(input int base, input logic [3:0] adj);
        logic signed [9:0] d;
        d = 10'(base) - {{6{adj[3]}}, adj};
        if (d < 10'sd0)
            d = d + H_TOT;
        else if (d >= H_TOT)
            d = d - H_TOT;
        return d[8:0];
    endfunction

    always_comb begin
        v_last    = pal_q ? VP_LAST : VN_LAST;
        line_end  = (hcnt == H_LAST);
        frame_end = line_end && (vcnt == v_last);

        h_nxt   = line_end ? 9'd0 : hcnt + 9'd1;
        v_nxt   = vcnt;
        adj_nxt = adj_q;
        pal_nxt = pal_q;
        if (line_end) begin
            adj_nxt = i_HADJ;
            v_nxt   = frame_end ? 9'd0 : vcnt + 9'd1;
        end
        if (frame_end)
            pal_nxt = i_PAL;

        // Strobes decode the upcoming counter value so they land with it.
        hs_s_pos = hs_pos(HS_START, adj_nxt);
        hs_e_pos = hs_pos(HS_END, adj_nxt);
        hs_r     = (h_nxt == hs_e_pos);
        hs_s     = (h_nxt == hs_s_pos) && !hs_r;
        hb_r     = (h_nxt == 9'(HB_END));
        hb_s     = (h_nxt == 9'(HB_START)) && !hb_r;
        vs_r     = (h_nxt == hs_s_pos) && (v_nxt == 9'(VS_LINES));
        vs_s     = (h_nxt == hs_s_pos) && (v_nxt == 9'd0) && !vs_r;
        stb_nxt  = {hs_s, hs_r, hb_s, hb_r, vs_s, vs_r};
    end

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            hcnt  <= H_LAST;
            vcnt  <= VN_LAST;
            adj_q <= '0;
            pal_q <= 1'b0;
            stb_q <= '0;
        end else if (i_CEN) begin
            hcnt  <= h_nxt;
            vcnt  <= v_nxt;
            adj_q <= adj_nxt;
            pal_q <= pal_nxt;
            stb_q <= stb_nxt;
        end
    end

    assign o_HCNT      = hcnt;
    assign o_VCNT      = vcnt;
    assign o_HSYNC_S   = stb_q[5];
    assign o_HSYNC_R   = stb_q[4];
    assign o_HBLANK_S  = stb_q[3];
    assign o_HBLANK_R  = stb_q[2];
    assign o_VSYNC_S   = stb_q[1];
    assign o_VSYNC_R   = stb_q[0];
    assign o_LINE_END  = line_end;
    assign o_FRAME_END = frame_end;

endmodule

// File: tb/tb_ika9958_sync_strobe_gen.sv
// Bench for ika9958_sync_strobe_gen: default, short-geometry and HS_END=HS_START
// instances checked against a position model, plus vector table and corner sequences.
module tb_ika9958_sync_strobe_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic       pal = 1'b0;
    logic [3:0] hadj = 4'd0;

    logic [8:0] hc [3];
    logic [8:0] vc [3];
    logic       hs_s [3];
    logic       hs_r [3];
    logic       hb_s [3];
    logic       hb_r [3];
    logic       vs_s [3];
    logic       vs_r [3];
    logic       le [3];
    logic       fe [3];

    int total = 0;
    int bad = 0;
    int eq_s_hits = 0;
    int eq_r_hits = 0;

    always #5 clk = ~clk;

    ika9958_sync_strobe_gen u_main (
        .i_CLK(clk), .i_RST_n(rst_n), .i_CEN(cen), .i_HADJ(hadj), .i_PAL(pal),
        .o_HCNT(hc[0]), .o_VCNT(vc[0]),
        .o_HSYNC_S(hs_s[0]), .o_HSYNC_R(hs_r[0]),
        .o_HBLANK_S(hb_s[0]), .o_HBLANK_R(hb_r[0]),
        .o_VSYNC_S(vs_s[0]), .o_VSYNC_R(vs_r[0]),
        .o_LINE_END(le[0]), .o_FRAME_END(fe[0])
    );

    ika9958_sync_strobe_gen #(
        .H_TOTAL(48), .HS_START(2), .HS_END(9), .HB_START(40), .HB_END(14),
        .V_NTSC(8), .V_PAL(11), .VS_LINES(3)
    ) u_small (
        .i_CLK(clk), .i_RST_n(rst_n), .i_CEN(cen), .i_HADJ(hadj), .i_PAL(pal),
        .o_HCNT(hc[1]), .o_VCNT(vc[1]),
        .o_HSYNC_S(hs_s[1]), .o_HSYNC_R(hs_r[1]),
        .o_HBLANK_S(hb_s[1]), .o_HBLANK_R(hb_r[1]),
        .o_VSYNC_S(vs_s[1]), .o_VSYNC_R(vs_r[1]),
        .o_LINE_END(le[1]), .o_FRAME_END(fe[1])
    );

    ika9958_sync_strobe_gen #(
        .HS_START(0), .HS_END(0)
    ) u_eq (
        .i_CLK(clk), .i_RST_n(rst_n), .i_CEN(cen), .i_HADJ(hadj), .i_PAL(pal),
        .o_HCNT(hc[2]), .o_VCNT(vc[2]),
        .o_HSYNC_S(hs_s[2]), .o_HSYNC_R(hs_r[2]),
        .o_HBLANK_S(hb_s[2]), .o_HBLANK_R(hb_r[2]),
        .o_VSYNC_S(vs_s[2]), .o_VSYNC_R(vs_r[2]),
        .o_LINE_END(le[2]), .o_FRAME_END(fe[2])
    );

    // Reference: raw position, latched adjust and frame mode, computed arithmetically.
    typedef struct {
        int ht, hss, hse, hbs, hbe, vn, vp, vsl;
        int h, v, adj, pal, run;
    } mdl_t;

    mdl_t m [3];

    typedef struct {
        int          n;
        logic [25:0] exp;
    } vec_t;

    vec_t tbl [10];

    function automatic mdl_t m_rst(mdl_t x);
        x.h   = x.ht - 1;
        x.v   = x.vn - 1;
        x.adj = 0;
        x.pal = 0;
        x.run = 0;
        return x;
    endfunction

    function automatic mdl_t mk(int ht, int hss, int hse, int hbs, int hbe,
                                int vn, int vp, int vsl);
        mdl_t x;
        x.ht = ht; x.hss = hss; x.hse = hse; x.hbs = hbs; x.hbe = hbe;
        x.vn = vn; x.vp = vp; x.vsl = vsl;
        return m_rst(x);
    endfunction

    function automatic int pmod(int a, int n);
        return ((a % n) + n) % n;
    endfunction

    function automatic mdl_t m_cen(mdl_t x, int adj, int p);
        int vt;
        vt = (x.pal != 0) ? x.vp : x.vn;
        x.run = 1;
        if (x.h == x.ht - 1) begin
            x.h   = 0;
            x.adj = adj;
            if (x.v == vt - 1) begin
                x.v   = 0;
                x.pal = p;
            end else begin
                x.v = x.v + 1;
            end
        end else begin
            x.h = x.h + 1;
        end
        return x;
    endfunction

    function automatic logic [25:0] m_out(mdl_t x);
        int ps, pe, vt;
        logic s_hs, r_hs, s_hb, r_hb, s_vs, r_vs, l, f;
        ps   = pmod(x.hss - x.adj, x.ht);
        pe   = pmod(x.hse - x.adj, x.ht);
        r_hs = (x.run != 0) && (x.h == pe);
        s_hs = (x.run != 0) && (x.h == ps) && !r_hs;
        r_hb = (x.run != 0) && (x.h == x.hbe);
        s_hb = (x.run != 0) && (x.h == x.hbs) && !r_hb;
        r_vs = (x.run != 0) && (x.h == ps) && (x.v == x.vsl);
        s_vs = (x.run != 0) && (x.h == ps) && (x.v == 0) && !r_vs;
        vt   = (x.pal != 0) ? x.vp : x.vn;
        l    = (x.h == x.ht - 1);
        f    = l && (x.v == vt - 1);
        return {9'(x.h), 9'(x.v), s_hs, r_hs, s_hb, r_hb, s_vs, r_vs, l, f};
    endfunction

    function automatic logic [25:0] dut_out(int k);
        return {hc[k], vc[k], hs_s[k], hs_r[k], hb_s[k], hb_r[k],
                vs_s[k], vs_r[k], le[k], fe[k]};
    endfunction

    function automatic vec_t mkv(int n, int h, int v, logic [5:0] s, logic l, logic f);
        vec_t t;
        t.n   = n;
        t.exp = {9'(h), 9'(v), s, l, f};
        return t;
    endfunction

    task automatic check(string nm, logic [25:0] act, logic [25:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s: got %h want %h (h,v,stb,le,fe)", nm, act, exp);
        end
    endtask

    task automatic check_i(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        int sadj;
        sadj = int'($signed(hadj));
        @(posedge clk);
        if (rst_n && cen)
            for (int k = 0; k < 3; k++)
                m[k] = m_cen(m[k], sadj, int'(pal));
        #1;
        for (int k = 0; k < 3; k++)
            check($sformatf("model_dut%0d", k), dut_out(k), m_out(m[k]));
        if (hs_s[2]) eq_s_hits++;
        if (hs_r[2]) eq_r_hits++;
    endtask

    task automatic goto_h(int k, int target);
        int n;
        n = 0;
        while (hc[k] !== 9'(target) && n < 2000) begin
            tick();
            n++;
        end
        check_i("goto_h", int'(hc[k]), target);
    endtask

    task automatic goto_v(int k, int target);
        int n;
        n = 0;
        while (vc[k] !== 9'(target) && n < 2000) begin
            tick();
            n++;
        end
        check_i("goto_v", int'(vc[k]), target);
    endtask

    task automatic wait_fe(int k, output int v_at);
        int n;
        n = 0;
        v_at = -1;
        while (n < 2000) begin
            tick();
            n++;
            if (fe[k]) begin
                v_at = int'(vc[k]);
                break;
            end
        end
    endtask

    task automatic scan(int n, output int s_at, output int r_at);
        s_at = -1;
        r_at = -1;
        repeat (n) begin
            tick();
            if (hs_s[0]) s_at = int'(hc[0]);
            if (hs_r[0]) r_at = int'(hc[0]);
        end
    endtask

    localparam logic [25:0] RST_MAIN = {9'd341, 9'd261, 6'b000000, 1'b1, 1'b1};

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_at, r_at, v_at, cnt, n_hsr, n_hbs;

        m[0] = mk(342, 0, 25, 284, 58, 262, 313, 3);
        m[1] = mk(48, 2, 9, 40, 14, 8, 11, 3);
        m[2] = mk(342, 0, 0, 284, 58, 262, 313, 3);

        tbl[0] = mkv(1,    0,   0, 6'b100010, 1'b0, 1'b0);
        tbl[1] = mkv(2,    1,   0, 6'b000000, 1'b0, 1'b0);
        tbl[2] = mkv(26,   25,  0, 6'b010000, 1'b0, 1'b0);
        tbl[3] = mkv(59,   58,  0, 6'b000100, 1'b0, 1'b0);
        tbl[4] = mkv(285,  284, 0, 6'b001000, 1'b0, 1'b0);
        tbl[5] = mkv(342,  341, 0, 6'b000000, 1'b1, 1'b0);
        tbl[6] = mkv(343,  0,   1, 6'b100000, 1'b0, 1'b0);
        tbl[7] = mkv(368,  25,  1, 6'b010000, 1'b0, 1'b0);
        tbl[8] = mkv(1027, 0,   3, 6'b100001, 1'b0, 1'b0);
        tbl[9] = mkv(1028, 1,   3, 6'b000000, 1'b0, 1'b0);

        repeat (3) tick();
        check("reset_state", dut_out(0), RST_MAIN);

        // Release reset with CEN on every clock, walk the vector table.
        rst_n = 1'b1;
        cen   = 1'b1;
        cnt   = 0;
        for (int i = 0; i < 10; i++) begin
            while (cnt < tbl[i].n) begin
                tick();
                cnt++;
            end
            check($sformatf("vec%0d", i), dut_out(0), tbl[i].exp);
        end

        // CEN on every 4th clock: each strobe high for exactly 4 clocks per line.
        n_hsr = 0;
        n_hbs = 0;
        repeat (342) begin
            cen = 1'b1;
            tick();
            if (hs_r[0]) n_hsr++;
            if (hb_s[0]) n_hbs++;
            cen = 1'b0;
            repeat (3) begin
                tick();
                if (hs_r[0]) n_hsr++;
                if (hb_s[0]) n_hbs++;
            end
        end
        check_i("cen4_hsync_r_clks", n_hsr, 4);
        check_i("cen4_hblank_s_clks", n_hbs, 4);
        cen = 1'b1;

        // Horizontal adjust is taken at the next line start only.
        goto_h(0, 100);
        hadj = 4'd7;
        scan(241, s_at, r_at);
        check_i("adj7_cur_line_s", s_at, -1);
        check_i("adj7_cur_line_r", r_at, -1);
        scan(342, s_at, r_at);
        check_i("adj7_next_s", s_at, 335);
        check_i("adj7_next_r", r_at, 18);
        goto_h(0, 200);
        hadj = 4'h8;
        scan(141, s_at, r_at);
        check_i("adjm8_cur_line_s", s_at, 335);
        check_i("adjm8_cur_line_r", r_at, -1);
        scan(342, s_at, r_at);
        check_i("adjm8_next_s", s_at, 8);
        check_i("adjm8_next_r", r_at, 33);
        hadj = 4'd0;

        // PAL selected mid-frame on the short-geometry instance.
        goto_v(1, 4);
        pal = 1'b1;
        wait_fe(1, v_at);
        check_i("pal_cur_frame_end", v_at, 7);
        wait_fe(1, v_at);
        check_i("pal_next_frame_end", v_at, 10);

        // Randomised run against the model.
        repeat (3000) begin
            cen = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) hadj = 4'($urandom);
            if ($urandom_range(0, 399) == 0) pal = ~pal;
            tick();
        end
        cen  = 1'b1;
        hadj = 4'd0;

        // Asynchronous reset mid-line.
        goto_h(0, 150);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_out(0), RST_MAIN);
        for (int k = 0; k < 3; k++)
            m[k] = m_rst(m[k]);
        check("async_reset_small", dut_out(1), m_out(m[1]));
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (400) tick();

        check_i("eq_set_never", eq_s_hits, 0);
        check_i("eq_reset_seen", int'(eq_r_hits > 0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
